// File: rtl/fft_pkg.sv
// Shared FFT datapath helpers: constant clog2, lgd width derivation, stride clamp.
package fft_pkg;

    localparam int DBW_DEF = 16;

    typedef logic [DBW_DEF-1:0] sample_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int lgw_of(input int maxlg);
        return clog2(maxlg + 1);
    endfunction

    function automatic int clamp_lg(input int lg, input int maxlg);
        return (lg > maxlg) ? maxlg : lg;
    endfunction

endpackage

// File: rtl/delay_line.sv
// Circular delay line: single-port RAM, combinational read of the old word, write at the clock edge.
module delay_line #(
    parameter int DBW = 16,
    parameter int AW  = 4
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  addr,
    input  logic [DBW-1:0] din,
    output logic [DBW-1:0] dout
);

    logic [DBW-1:0] mem [2**AW];

    // Read sees the word written D transfers ago; the write lands at the edge.
    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/stride_commutator.sv
// Radix-2 delay-commutator producing stride-D reordered pairs, D = 2^lg.
// STRIDE_COMMUTATOR_RUNTIME_LGD_EN adds the lgd port; otherwise D is fixed at 2^MAXLG.
module stride_commutator
    import fft_pkg::*;
#(
    parameter int DBW   = 16,
    parameter int MAXLG = 4,
    localparam int LGW  = lgw_of(MAXLG)
) (
    input  logic           clk,
    input  logic           rstx,
    input  logic           clr,
`ifdef STRIDE_COMMUTATOR_RUNTIME_LGD_EN
    input  logic [LGW-1:0] lgd,
`endif
    input  logic           in_valid,
    input  logic [DBW-1:0] din_a,
    input  logic [DBW-1:0] din_b,
    output logic           out_valid,
    output logic [DBW-1:0] dout_x,
    output logic [DBW-1:0] dout_y,
    output logic           out_first
);

    localparam int TW = MAXLG + 1;

    logic [TW-1:0]    t_q, t_d;
    logic             primed_q, primed_d;
    logic [MAXLG-1:0] addr;
    logic             s;
    logic [TW-1:0]    dm1;
    logic             xfer, emit;
    logic [DBW-1:0]   bp, ud, u, v;
    logic             out_valid_q, out_first_q;
    logic [DBW-1:0]   x_q, y_q;

`ifdef STRIDE_COMMUTATOR_RUNTIME_LGD_EN
    logic [LGW-1:0]   lg_q, lg_in, lg_cur;
    logic             load_q;
    logic [MAXLG-1:0] mask;

    assign lg_in = LGW'(clamp_lg(int'(lgd), MAXLG));
    // First cycle after reset release uses lgd directly so a transfer there is not lost.
    assign lg_cur = load_q ? lg_in : lg_q;

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            lg_q   <= LGW'(MAXLG);
            load_q <= 1'b1;
        end else begin
            if (clr || load_q) begin
                lg_q <= lg_in;
            end
            load_q <= 1'b0;
        end
    end

    assign mask = MAXLG'((32'd1 << lg_cur) - 32'd1);
    assign addr = t_q[MAXLG-1:0] & mask;
    assign s    = t_q[lg_cur];
    assign dm1  = TW'(mask);
`else
    assign addr = t_q[MAXLG-1:0];
    assign s    = t_q[MAXLG];
    assign dm1  = {1'b0, {MAXLG{1'b1}}};
`endif

    assign xfer = in_valid & ~clr;
    assign emit = xfer & primed_q;

    always_comb begin
        t_d      = t_q;
        primed_d = primed_q;
        if (clr) begin
            t_d      = '0;
            primed_d = 1'b0;
        end else if (in_valid) begin
            t_d = t_q + TW'(1);
            if (t_q == dm1) begin
                primed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            t_q      <= '0;
            primed_q <= 1'b0;
        end else begin
            t_q      <= t_d;
            primed_q <= primed_d;
        end
    end

    assign u = s ? bp : din_a;
    assign v = s ? din_a : bp;

    delay_line #(.DBW(DBW), .AW(MAXLG)) u_line_b (
        .clk  (clk),
        .we   (xfer),
        .addr (addr),
        .din  (din_b),
        .dout (bp)
    );

    delay_line #(.DBW(DBW), .AW(MAXLG)) u_line_u (
        .clk  (clk),
        .we   (xfer),
        .addr (addr),
        .din  (u),
        .dout (ud)
    );

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            out_valid_q <= emit;
            out_first_q <= emit & s & (addr == '0);
            if (emit) begin
                x_q <= ud;
                y_q <= v;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign dout_x    = x_q;
    assign dout_y    = y_q;

endmodule
